// File: rtl/tile_flip_pkg.sv
// Shared definitions for the tile-flip monitor.
// Holds the FSM state encoding, tile count, BCD saturation limit and two small
// bit-vector helpers (population count and lowest set bit).
package tile_flip_pkg;

  localparam int unsigned NUM_TILES = 16;
  localparam logic [15:0] BCD_MAX  = 16'h9999;

  typedef enum logic [1:0] {
    StIdle,
    StPlaying,
    StWon
  } flip_state_e;

  // Number of set bits in a tile vector (0..16).
  function automatic logic [4:0] popcount16(input logic [15:0] v);
    logic [4:0] cnt;
    cnt = '0;
    for (int i = 0; i < 16; i++) begin
      cnt = cnt + {4'd0, v[i]};
    end
    return cnt;
  endfunction

  // Index of the lowest set bit; 0 when the vector is empty.
  function automatic logic [3:0] lowest_set(input logic [15:0] v);
    logic [3:0] idx;
    idx = '0;
    for (int i = 15; i >= 0; i--) begin
      if (v[i]) idx = 4'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/bcd_sat_adder.sv
// Four-digit BCD adder with saturation.
// Adds a small binary increment (0..31) to a 16-bit packed-BCD value and clamps
// the result at 9999 instead of wrapping.
//   bcd_i  : current value, four BCD digits, [15:12] thousands
//   inc_i  : binary increment
//   sum_o  : saturated BCD sum
module bcd_sat_adder
  import tile_flip_pkg::*;
(
  input  logic [15:0] bcd_i,
  input  logic [4:0]  inc_i,
  output logic [15:0] sum_o
);

  logic [3:0]  inc_ones;
  logic [3:0]  inc_tens;
  logic [15:0] sum_raw;
  logic        carry_out;

  // Split the binary increment into tens/ones BCD digits.
  always_comb begin
    logic [4:0] tmp;
    tmp      = '0;
    inc_ones = inc_i[3:0];
    inc_tens = 4'd0;
    if (inc_i >= 5'd30) begin
      tmp      = inc_i - 5'd30;
      inc_ones = tmp[3:0];
      inc_tens = 4'd3;
    end else if (inc_i >= 5'd20) begin
      tmp      = inc_i - 5'd20;
      inc_ones = tmp[3:0];
      inc_tens = 4'd2;
    end else if (inc_i >= 5'd10) begin
      tmp      = inc_i - 5'd10;
      inc_ones = tmp[3:0];
      inc_tens = 4'd1;
    end
  end

  // Ripple through the four digits with decimal carry.
  always_comb begin
    logic [4:0] dsum;
    logic [4:0] dfix;
    logic [3:0] addend;
    logic       carry;
    sum_raw = '0;
    carry   = 1'b0;
    dsum    = '0;
    dfix    = '0;
    for (int i = 0; i < 4; i++) begin
      if (i == 0)      addend = inc_ones;
      else if (i == 1) addend = inc_tens;
      else             addend = 4'd0;
      dsum = {1'b0, bcd_i[4*i +: 4]} + {1'b0, addend} + {4'd0, carry};
      if (dsum > 5'd9) begin
        dfix  = dsum - 5'd10;
        carry = 1'b1;
      end else begin
        dfix  = dsum;
        carry = 1'b0;
      end
      sum_raw[4*i +: 4] = dfix[3:0];
    end
    carry_out = carry;
  end

  assign sum_o = carry_out ? BCD_MAX : sum_raw;

endmodule

// File: rtl/flip_monitor.sv
// Tile-flip game monitor.
// Debounces the 16 tile states, accepts a change once it has been seen for
// SETTLE_CYCLES consecutive samples, counts flipped tiles as a saturating BCD
// move counter and detects reaching the level's target pattern.
//   clk, reset  : clock and synchronous active-high reset
//   start       : pulse that begins/restarts a round
//   states      : live tile states, bit i is tile i
//   target      : winning pattern, only looked at when a change is accepted
//   move_bcd    : moves so far, four BCD digits
//   flip_pulse  : one-cycle strobe per accepted change
//   flip_index  : lowest tile of the last accepted change
//   playing/won : FSM status
module flip_monitor
  import tile_flip_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [NUM_TILES-1:0] states,
  input  logic [NUM_TILES-1:0] target,
  output logic [15:0]          move_bcd,
  output logic                 flip_pulse,
  output logic [3:0]           flip_index,
  output logic                 playing,
  output logic                 won
);

  localparam logic [8:0] SettleW = 9'(SETTLE_CYCLES);

  flip_state_e          state_q, state_d;
  logic [NUM_TILES-1:0] committed_q, committed_d;
  logic [NUM_TILES-1:0] cand_q, cand_d;
  logic [7:0]           cnt_q, cnt_d;
  logic [15:0]          move_q, move_d;
  logic                 pulse_q, pulse_d;
  logic [3:0]           index_q, index_d;
  logic                 playing_q, playing_d;
  logic                 won_q, won_d;

  logic [NUM_TILES-1:0] diff;
  logic [4:0]           diff_cnt;
  logic [15:0]          move_sum;
  logic [8:0]           sample_cnt;
  logic                 commit;

  assign diff     = states ^ committed_q;
  assign diff_cnt = popcount16(diff);

  // cnt_q holds how many identical samples of cand_q have been seen so far;
  // sample_cnt includes the current cycle, so a value held from cycle t
  // reaches SETTLE_CYCLES in cycle t+SETTLE_CYCLES-1 and commits on that edge.
  assign sample_cnt = (states == cand_q) ? ({1'b0, cnt_q} + 9'd1) : 9'd1;
  assign commit     = (sample_cnt == SettleW) && (diff != '0);

  bcd_sat_adder u_adder (
    .bcd_i (move_q),
    .inc_i (diff_cnt),
    .sum_o (move_sum)
  );

  always_comb begin
    state_d     = state_q;
    committed_d = committed_q;
    cand_d      = cand_q;
    cnt_d       = cnt_q;
    move_d      = move_q;
    pulse_d     = 1'b0;
    index_d     = index_q;

    unique case (state_q)
      StIdle, StWon: begin
        if (start) begin
          state_d     = StPlaying;
          committed_d = states;
          cand_d      = states;
          cnt_d       = '0;
          move_d      = '0;
        end
      end
      StPlaying: begin
        if (start) begin
          // Restart wins over any commit due on this edge.
          committed_d = states;
          cand_d      = states;
          cnt_d       = '0;
          move_d      = '0;
        end else begin
          cand_d = states;
          cnt_d  = (sample_cnt > SettleW) ? SettleW[7:0] : sample_cnt[7:0];
          if (commit) begin
            committed_d = states;
            pulse_d     = 1'b1;
            index_d     = lowest_set(diff);
            move_d      = move_sum;
            if (states == target) state_d = StWon;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    playing_d = (state_d == StPlaying);
    won_d     = (state_d == StWon);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      committed_q <= '0;
      cand_q      <= '0;
      cnt_q       <= '0;
      move_q      <= '0;
      pulse_q     <= 1'b0;
      index_q     <= '0;
      playing_q   <= 1'b0;
      won_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      committed_q <= committed_d;
      cand_q      <= cand_d;
      cnt_q       <= cnt_d;
      move_q      <= move_d;
      pulse_q     <= pulse_d;
      index_q     <= index_d;
      playing_q   <= playing_d;
      won_q       <= won_d;
    end
  end

  assign move_bcd   = move_q;
  assign flip_pulse = pulse_q;
  assign flip_index = index_q;
  assign playing    = playing_q;
  assign won        = won_q;

endmodule
